// File: rtl/bcd_scan_counter.sv
// 4-digit BCD up/down counter with a time-multiplexed digit/anode scan stage.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits (d0 always lit).
module bcd_scan_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        clear,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic [15:0] value,
  output logic        wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   value_q, value_d, step_val;
  logic          wrap_q, wrap_d, carry, tick;
  logic [SW-1:0] tmr_q, tmr_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d, digit_q, digit_d, nib;
  logic          blank;

  assign tick = en && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (clear || tick) presc_d = '0;
    else if (en)       presc_d = presc_q + PW'(1);
  end

  // Ripple carry/borrow through the nibbles; a carry out of d3 is a wrap.
  always_comb begin
    step_val = value_q;
    carry    = 1'b1;
    nib      = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        nib = value_q[i*4 +: 4];
        if (up) begin
          if (nib >= 4'd9) step_val[i*4 +: 4] = 4'd0;
          else begin
            step_val[i*4 +: 4] = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0 || nib > 4'd9) step_val[i*4 +: 4] = 4'd9;
          else begin
            step_val[i*4 +: 4] = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (clear) value_d = 16'h0000;
    else if (tick) begin
      value_d = step_val;
      wrap_d  = carry;
    end
  end

  always_comb begin
    tmr_d = tmr_q + SW'(1);
    idx_d = idx_q;
    if (tmr_q == SW'(SCAN_DIV - 1)) begin
      tmr_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Anode and digit both derive from idx_d so they always switch together.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_d != 2'd0) && ((value_q >> {idx_d, 2'b00}) == 16'h0000);
`else
    blank = 1'b0;
`endif
    an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_d);
    digit_d = value_q[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      value_q <= 16'h0000;
      wrap_q  <= 1'b0;
      tmr_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1110;
      digit_q <= 4'h0;
    end else begin
      presc_q <= presc_d;
      value_q <= value_d;
      wrap_q  <= wrap_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign digit = digit_q;

endmodule
